// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences one word read or write per request onto a 1Mx16
// asynchronous SRAM with fixed setup, access and hold phases. Every pin is
// driven from a flop.
`timescale 1ns/1ps
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_be,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data
);

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_IDLE   = 3'd0;
  localparam logic [SW-1:0] S_SETUP  = 3'd1;
  localparam logic [SW-1:0] S_ACCESS = 3'd2;
  localparam logic [SW-1:0] S_HOLD   = 3'd3;
  localparam logic [SW-1:0] S_RESP   = 3'd4;

  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_we_q, op_we_d;
  logic          ce_q, ce_d;
  logic          ub_q, ub_d;
  logic          lb_q, lb_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          drv_q, drv_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ready_q, ready_d;

  // Next state plus the pin values for the state being entered, so that
  // pins change together with the state on the same edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_we_d     = op_we_q;
    ce_d        = ce_q;
    ub_d        = ub_q;
    lb_d        = lb_q;
    oe_d        = oe_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    drv_d       = drv_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SETUP;
          op_we_d = req_we;
          ce_d    = 1'b0;
          ub_d    = ~req_be[1];
          lb_d    = ~req_be[0];
          oe_d    = req_we;
          we_d    = 1'b1;
          addr_d  = req_addr;
          dout_d  = req_wdata;
          drv_d   = req_we;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = CNT_LOAD;
        we_d    = ~op_we_q;
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          we_d    = 1'b1;
          oe_d    = 1'b1;
          if (!op_we_q) begin
            rdata_d = Data;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        state_d     = S_RESP;
        ce_d        = 1'b1;
        ub_d        = 1'b1;
        lb_d        = 1'b1;
        oe_d        = 1'b1;
        we_d        = 1'b1;
        drv_d       = 1'b0;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ce_d    = 1'b1;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        drv_d   = 1'b0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and pin registers; reset parks all strobes high and frees the bus.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_we_q     <= 1'b0;
      ce_q        <= 1'b1;
      ub_q        <= 1'b1;
      lb_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      addr_q      <= '0;
      dout_q      <= '0;
      drv_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_we_q     <= op_we_d;
      ce_q        <= ce_d;
      ub_q        <= ub_d;
      lb_q        <= lb_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      drv_q       <= drv_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  assign Data      = drv_q ? dout_q : {DW{1'bz}};
  assign CE        = ce_q;
  assign UB        = ub_q;
  assign LB        = lb_q;
  assign OE        = oe_q;
  assign WE        = we_q;
  assign ADDR      = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed table-driven checks of sram_ctrl pin sequencing,
// plus reset/abort sequences and WAIT_CYCLES=1/15 instances.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_be;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  // Bus probe: when the DUT is expected to release the bus, the bench pulls
  // it to 0 so any stray DUT drive shows up as a nonzero value.
  logic        exp_drv;
  logic [15:0] mem [256];

  assign Data = (!CE && !OE) ? mem[ADDR[7:0]] : (exp_drv ? 16'hzzzz : 16'h0000);

  // SRAM model write port with byte lanes.
  always @(posedge Clk) begin
    if (!CE && !WE) begin
      if (!UB) mem[ADDR[7:0]][15:8] <= Data[15:8];
      if (!LB) mem[ADDR[7:0]][7:0]  <= Data[7:0];
    end
  end

  // Auxiliary instances for the WAIT_CYCLES sweep.
  logic        aux_valid [2];
  logic        aux_ready [2];
  logic        aux_rsp   [2];
  logic [15:0] aux_rdata [2];
  logic        aux_ce [2], aux_ub [2], aux_lb [2], aux_oe [2], aux_we [2];
  logic [19:0] aux_addr  [2];
  wire  [15:0] aux_data0, aux_data1;

  assign aux_data0 = !aux_oe[0] ? 16'hA5A5 : 16'hzzzz;
  assign aux_data1 = !aux_oe[1] ? 16'hA5A5 : 16'hzzzz;

  always #5 Clk = ~Clk;

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
  );

  sram_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(Clk), .Reset(Reset), .req_valid(aux_valid[0]), .req_ready(aux_ready[0]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(aux_rsp[0]), .rsp_rdata(aux_rdata[0]),
    .CE(aux_ce[0]), .UB(aux_ub[0]), .LB(aux_lb[0]), .OE(aux_oe[0]), .WE(aux_we[0]),
    .ADDR(aux_addr[0]), .Data(aux_data0)
  );

  sram_ctrl #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(Clk), .Reset(Reset), .req_valid(aux_valid[1]), .req_ready(aux_ready[1]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(aux_rsp[1]), .rsp_rdata(aux_rdata[1]),
    .CE(aux_ce[1]), .UB(aux_ub[1]), .LB(aux_lb[1]), .OE(aux_oe[1]), .WE(aux_we[1]),
    .ADDR(aux_addr[1]), .Data(aux_data1)
  );

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        hold;
  } txn_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one transaction on the main DUT starting at a negedge with the
  // controller idle; checks every pin in every cycle up to the return of
  // req_ready, then returns at the negedge of that cycle.
  task automatic run_txn(input txn_t t, input string nm);
    logic [6:0]  exp_pins;
    logic [15:0] exp_data;
    logic        act_c;
    int          last;
    last = W + 4;
    chk($sformatf("%s.ready_in", nm), 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1;
    req_we    = t.we;
    req_be    = t.be;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    @(posedge Clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        req_we    = ~t.we;
        req_be    = ~t.be;
        req_addr  = t.addr ^ 20'hF0F0F;
        req_wdata = ~t.wdata;
        if (!t.hold) req_valid = 1'b0;
      end
      act_c   = (c <= W + 2);
      exp_drv = t.we && act_c;
      #1;
      exp_pins[6] = ~act_c;
      exp_pins[5] = act_c ? ~t.be[1] : 1'b1;
      exp_pins[4] = act_c ? ~t.be[0] : 1'b1;
      exp_pins[3] = ~(~t.we && (c <= W + 1));
      exp_pins[2] = ~(t.we && (c >= 2) && (c <= W + 1));
      exp_pins[1] = (c == W + 3);
      exp_pins[0] = (c == last);
      chk($sformatf("%s.pins{CE,UB,LB,OE,WE,rv,rdy} c%0d", nm, c),
          64'({CE, UB, LB, OE, WE, rsp_valid, req_ready}), 64'(exp_pins));
      chk($sformatf("%s.addr c%0d", nm, c), 64'(ADDR), 64'(t.addr));
      if (t.we) exp_data = act_c ? t.wdata : 16'h0000;
      else      exp_data = (c <= W + 1) ? t.exp_rdata : 16'h0000;
      chk($sformatf("%s.data c%0d", nm, c), 64'(Data), 64'(exp_data));
      if (c == W + 3)
        chk($sformatf("%s.rdata", nm), 64'(rsp_rdata), 64'(t.exp_rdata));
    end
  endtask

  // One transaction on an auxiliary instance: response cycle and WE pulse
  // width or read data.
  task automatic aux_txn(input int k, input int w, input logic we);
    int          rsp_c;
    int          we_low;
    logic [15:0] rd;
    rsp_c  = 0;
    we_low = 0;
    rd     = 16'h0000;
    req_we    = we;
    req_be    = 2'b11;
    req_addr  = 20'h00077;
    req_wdata = 16'h1357;
    aux_valid[k] = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 30 && rsp_c == 0; c++) begin
      @(negedge Clk);
      aux_valid[k] = 1'b0;
      #1;
      if (!aux_we[k]) we_low++;
      if (aux_rsp[k]) begin
        rsp_c = c;
        rd    = aux_rdata[k];
      end
    end
    chk($sformatf("aux%0d.w%0d.we%0b.rsp_cycle", k, w, we), 64'(rsp_c), 64'(w + 3));
    if (we) chk($sformatf("aux%0d.w%0d.we_pulse", k, w), 64'(we_low), 64'(w));
    else    chk($sformatf("aux%0d.w%0d.rdata", k, w), 64'(rd), 64'(16'hA5A5));
    @(negedge Clk);
    #1;
  endtask

  txn_t vecs [10];

  initial begin
    logic rsp_seen;

    vecs[0] = '{we:1'b1, be:2'b11, addr:20'h00123, wdata:16'hBEEF, exp_rdata:16'h0000, hold:1'b0};
    vecs[1] = '{we:1'b0, be:2'b11, addr:20'h00123, wdata:16'h0000, exp_rdata:16'hBEEF, hold:1'b0};
    vecs[2] = '{we:1'b1, be:2'b11, addr:20'h00010, wdata:16'hFFFF, exp_rdata:16'hBEEF, hold:1'b0};
    vecs[3] = '{we:1'b1, be:2'b01, addr:20'h00010, wdata:16'h12AB, exp_rdata:16'hBEEF, hold:1'b0};
    vecs[4] = '{we:1'b0, be:2'b11, addr:20'h00010, wdata:16'h0000, exp_rdata:16'hFFAB, hold:1'b0};
    vecs[5] = '{we:1'b0, be:2'b11, addr:20'h00123, wdata:16'h0000, exp_rdata:16'hBEEF, hold:1'b1};
    vecs[6] = '{we:1'b1, be:2'b11, addr:20'h00040, wdata:16'h5555, exp_rdata:16'hBEEF, hold:1'b1};
    vecs[7] = '{we:1'b0, be:2'b11, addr:20'h00040, wdata:16'h0000, exp_rdata:16'h5555, hold:1'b0};
    vecs[8] = '{we:1'b1, be:2'b00, addr:20'h00040, wdata:16'h0000, exp_rdata:16'h5555, hold:1'b0};
    vecs[9] = '{we:1'b0, be:2'b11, addr:20'h00040, wdata:16'h0000, exp_rdata:16'h5555, hold:1'b0};

    Reset        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_be       = 2'b00;
    req_addr     = 20'h0;
    req_wdata    = 16'h0;
    exp_drv      = 1'b0;
    aux_valid[0] = 1'b0;
    aux_valid[1] = 1'b0;

    // Reset values.
    #12;
    chk("reset.pins{CE,UB,LB,OE,WE,rv,rdy}", 64'({CE, UB, LB, OE, WE, rsp_valid, req_ready}), 64'(7'b1111101));
    chk("reset.addr", 64'(ADDR), 64'(20'h0));
    chk("reset.rdata", 64'(rsp_rdata), 64'(16'h0));
    chk("reset.data", 64'(Data), 64'(16'h0));

    // Read in flight, then reset during ACCESS.
    @(negedge Clk);
    Reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_be    = 2'b11;
    req_addr  = 20'h00005;
    @(posedge Clk);
    @(negedge Clk);
    req_valid = 1'b0;
    @(negedge Clk);
    #1;
    chk("abort_rd.in_access{CE,OE}", 64'({CE, OE}), 64'(2'b00));
    Reset = 1'b0;
    #1;
    chk("abort_rd.pins{CE,UB,LB,OE,WE,rv,rdy}", 64'({CE, UB, LB, OE, WE, rsp_valid, req_ready}), 64'(7'b1111101));
    chk("abort_rd.addr", 64'(ADDR), 64'(20'h0));
    chk("abort_rd.rdata", 64'(rsp_rdata), 64'(16'h0));
    chk("abort_rd.data", 64'(Data), 64'(16'h0));
    @(negedge Clk);
    Reset = 1'b1;

    // Directed table, issued back to back from the first edge after release.
    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Write aborted by reset during ACCESS.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 2'b11;
    req_addr  = 20'h00050;
    req_wdata = 16'h1234;
    @(posedge Clk);
    @(negedge Clk);
    req_valid = 1'b0;
    exp_drv   = 1'b1;
    @(negedge Clk);
    #1;
    chk("abort_wr.in_access{CE,WE}", 64'({CE, WE}), 64'(2'b00));
    Reset   = 1'b0;
    exp_drv = 1'b0;
    #1;
    chk("abort_wr.{CE,OE,WE,rv}", 64'({CE, OE, WE, rsp_valid}), 64'(4'b1110));
    chk("abort_wr.data", 64'(Data), 64'(16'h0));
    @(negedge Clk);
    Reset    = 1'b1;
    rsp_seen = 1'b0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge Clk);
      #1;
      rsp_seen = rsp_seen | rsp_valid;
    end
    chk("abort_wr.no_rsp", 64'(rsp_seen), 64'(1'b0));

    // WAIT_CYCLES sweep.
    aux_txn(0, 1, 1'b1);
    aux_txn(0, 1, 1'b0);
    aux_txn(1, 15, 1'b1);
    aux_txn(1, 15, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Multi-cycle controller between the SLC-3 memory subsystem and the external 1Mx16 asynchronous SRAM. It accepts one word read or write per request over a valid/ready handshake and sequences the active-low chip pins with fixed setup, access and hold phases. It drives the shared 16-bit data bus through an internal tristate, and returns read data and a completion strobe to the requester. Every SRAM pin is driven from a flop, so pins never glitch.

## Interface
- WAIT_CYCLES, default 2: number of ACCESS-state cycles; legal range 1..15.
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept; high only in IDLE.
- req_we  input  1  1 = write, 0 = read.
- req_be  input  2  byte enables; bit1 = upper byte, bit0 = lower byte.
- req_addr  input  20  word address.
- req_wdata  input  16  write data.
- rsp_valid  output  1  one-cycle completion strobe, for reads and writes.
- rsp_rdata  output  16  last read word; holds until the next read completes.
- CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low.
- ADDR  output  20  SRAM address.
- Data  inout  16  SRAM data bus, type wire.

## Operation
- The state machine has five states: IDLE, SETUP, ACCESS, HOLD, RESP.
- **Accept:**
  - A request is accepted on a rising edge where req_valid and req_ready are both 1.
  - On that edge, req_we, req_be, req_addr and req_wdata are latched.
  - After acceptance, input changes are ignored until the next acceptance.
- **IDLE:**
  - All strobes are 1.
  - Data is released (Z).
  - ADDR holds its last value.
- **SETUP (1 cycle):**
  - CE=0 and ADDR = latched address.
  - UB = ~be[1] and LB = ~be[0].
  - Read: OE=0.
  - Write: OE=1, WE=1, and Data is driven with the latched wdata.
- **ACCESS (WAIT_CYCLES cycles):**
  - Pins are as in SETUP, except WE=0 for a write.
  - A 4-bit counter loads WAIT_CYCLES-1 on entry and decrements each cycle; the state exits when the count is 0.
  - Read: Data is sampled into rsp_rdata on the edge that ends the final ACCESS cycle.
- **HOLD (1 cycle):**
  - WE=1 and OE=1; CE, UB, LB, ADDR are unchanged.
  - Write: Data is still driven (data hold after the WE rising edge).
- **RESP (1 cycle):**
  - All strobes are 1 and Data is released.
  - rsp_valid = 1. This is the only state in which it is 1.
  - The next state is always IDLE. No request is accepted in RESP.
- **Pin timing:** pin values listed per state are the values present throughout that state. They are registered and updated on the edge entering the state.
- **Byte enables:** req_be = 2'b00 still runs the full sequence with UB=LB=1; this is a legal no-op access.
- **Write protection:** the bus driver is enabled only in SETUP, ACCESS and HOLD of a write. Data is never driven while OE=0.
- **rsp_rdata:** unchanged by writes.

## Timing
- **Accept to response:** for acceptance on edge 0, rsp_valid is high in cycle WAIT_CYCLES+3 after that edge.
  - Cycle 1 = SETUP.
  - Cycles 2..WAIT_CYCLES+1 = ACCESS.
  - Cycle WAIT_CYCLES+2 = HOLD.
  - Cycle WAIT_CYCLES+3 = RESP.
- **Occupancy:** req_ready returns to 1 in cycle WAIT_CYCLES+4. Maximum throughput is one request per WAIT_CYCLES+4 cycles.
- **WE pulse:** the WE low pulse is exactly WAIT_CYCLES cycles. Address and data are stable one cycle before WE falls and one cycle after WE rises.
- **Read capture:** rsp_rdata is valid in the RESP cycle, coincident with rsp_valid.
- **Held request:** if req_valid stays 1 through RESP, the request is re-accepted on the first IDLE edge; each acceptance is a separate access.
- **Reset values (asynchronous, while Reset=0):**
  - State = IDLE.
  - CE=UB=LB=OE=WE=1.
  - ADDR=0 and Data=Z.
  - rsp_valid=0, rsp_rdata=0.
  - req_ready=1, since it is decoded from IDLE.
- **Reset mid-operation:**
  - Strobes go high and the bus is released immediately.
  - The in-flight request is dropped with no rsp_valid.
  - The write may be partial in the SRAM.
- **Reset release:** after Reset is released, the first acceptance is possible on the first rising edge.

## Test plan
- **Reset:** hold Reset=0 with a read in flight (WAIT_CYCLES=2) -> all strobes 1, ADDR=0, Data=Z, rsp_valid=0, rsp_rdata=0, req_ready=1. After release, accept on the next edge.
- **Single write:** WAIT_CYCLES=2, write addr 0x00123, data 0xBEEF, be=2'b11.
  - -> CE low in cycles 1-4; WE low in cycles 2-3 only.
  - -> Data=0xBEEF in cycles 1-4; rsp_valid in cycle 5 only; req_ready=1 in cycle 6.
- **Read-back:** SRAM model returns 0xBEEF at 0x00123 -> OE low in cycles 1-3, WE never low, Data not driven by the DUT, rsp_rdata=0xBEEF with rsp_valid in cycle 5.
- **Byte write:** be=2'b01 write 0x12AB to 0x00010 over 0xFFFF -> UB=1 and LB=0 throughout. A later read returns 0xFFAB.
- **Back-to-back:** req_valid held high for read, write, read -> acceptances exactly 6 cycles apart; exactly three rsp_valid pulses; rsp_rdata unchanged across the write.
- **Abort and parameter sweep:**
  - Assert Reset=0 during a write's ACCESS -> WE and CE rise asynchronously, no rsp_valid.
  - Repeat the directed write/read with WAIT_CYCLES=1 and WAIT_CYCLES=15 -> rsp_valid in cycles 4 and 18 respectively.
